spi_flash_rd_seq: RTL

//  Bus-master sequencer that drives the 8-bit register port of the SPI master to do SPI-flash

---
 rtl/spi_flash_rd_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_flash_rd_seq.sv
// SPI-flash READ (0x03) burst sequencer driving the 8-bit register port of an SPI master.
// One byte is kept in flight at a time; received bytes leave on a valid/ready stream.
module spi_flash_rd_seq #(
    parameter logic [7:0] SPCR_VAL = 8'h50,
    parameter logic [7:0] CS_ON    = 8'hE1,
    parameter logic [7:0] CS_OFF   = 8'hF0,
    parameter int         POLL_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic        err,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [3:0]  adr_o,
    output logic        we_o,
    output logic [7:0]  dat_o,
    input  logic [7:0]  dat_i,
    input  logic        ack_i
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CFG   = 4'd1;
    localparam logic [3:0] S_CSON  = 4'd2;
    localparam logic [3:0] S_TXW   = 4'd3;
    localparam logic [3:0] S_POLL  = 4'd4;
    localparam logic [3:0] S_RXR   = 4'd5;
    localparam logic [3:0] S_OUT   = 4'd6;
    localparam logic [3:0] S_CSOFF = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [3:0] ADR_SPCR   = 4'd0;
    localparam logic [3:0] ADR_SPSR   = 4'd1;
    localparam logic [3:0] ADR_SPDR   = 4'd2;
    localparam logic [3:0] ADR_SOFTCS = 4'd5;

    localparam int PW = $clog2(POLL_MAX + 1);

    logic [3:0]    state;
    logic [23:0]   addr_q;
    logic [8:0]    idx;
    logic [8:0]    remaining;
    logic [PW-1:0] poll_cnt;
    logic          err_flag;

    logic [7:0]    tx_byte;
    logic [3:0]    bus_adr;
    logic          bus_we;
    logic [7:0]    bus_dat;
    logic          bus_state;

    // Bytes 0..3 are the command and address; every later byte is a dummy that clocks data in.
    always_comb begin
        tx_byte = 8'h00;
        case (idx)
            9'd0:    tx_byte = 8'h03;
            9'd1:    tx_byte = addr_q[23:16];
            9'd2:    tx_byte = addr_q[15:8];
            9'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        bus_adr   = 4'd0;
        bus_we    = 1'b0;
        bus_dat   = 8'h00;
        bus_state = 1'b1;
        case (state)
            S_CFG:   begin bus_adr = ADR_SPCR;   bus_we = 1'b1; bus_dat = SPCR_VAL; end
            S_CSON:  begin bus_adr = ADR_SOFTCS; bus_we = 1'b1; bus_dat = CS_ON;    end
            S_TXW:   begin bus_adr = ADR_SPDR;   bus_we = 1'b1; bus_dat = tx_byte;  end
            S_POLL:  bus_adr = ADR_SPSR;
            S_RXR:   bus_adr = ADR_SPDR;
            S_CSOFF: begin bus_adr = ADR_SOFTCS; bus_we = 1'b1; bus_dat = CS_OFF;   end
            default: bus_state = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            idx       <= '0;
            remaining <= '0;
            poll_cnt  <= '0;
            err_flag  <= 1'b0;
            cyc_o     <= 1'b0;
            adr_o     <= '0;
            we_o      <= 1'b0;
            dat_o     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else if (state == S_IDLE) begin
            if (req_valid) begin
                addr_q    <= req_addr;
                remaining <= {1'b0, req_len};
                idx       <= '0;
                poll_cnt  <= '0;
                err_flag  <= 1'b0;
                state     <= (req_len == 8'd0) ? S_DONE : S_CFG;
            end
        end else if (bus_state) begin
            // A cycle with cyc_o low always separates two accesses.
            if (!cyc_o) begin
                cyc_o <= 1'b1;
                adr_o <= bus_adr;
                we_o  <= bus_we;
                dat_o <= bus_dat;
            end else if (ack_i) begin
                cyc_o <= 1'b0;
                we_o  <= 1'b0;
                case (state)
                    S_CFG:  state <= S_CSON;
                    S_CSON: state <= S_TXW;
                    S_TXW: begin
                        poll_cnt <= '0;
                        state    <= S_POLL;
                    end
                    S_POLL: begin
                        if (!dat_i[0]) begin
                            state <= S_RXR;
                        end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                            err_flag <= 1'b1;
                            state    <= S_CSOFF;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                    S_RXR: begin
                        if (idx < 9'd4) begin
                            idx   <= idx + 9'd1;
                            state <= S_TXW;
                        end else begin
                            rd_data  <= dat_i;
                            rd_valid <= 1'b1;
                            state    <= S_OUT;
                        end
                    end
                    default: state <= S_DONE;
                endcase
            end
        end else if (state == S_OUT) begin
            // Holding here without bus traffic stalls SCK until the consumer is ready.
            if (rd_ready) begin
                rd_valid  <= 1'b0;
                idx       <= idx + 9'd1;
                remaining <= remaining - 9'd1;
                state     <= (remaining == 9'd1) ? S_CSOFF : S_TXW;
            end
        end else begin
            state <= S_IDLE;
        end
    end

    assign req_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = done & err_flag;
    assign stb_o     = cyc_o;

endmodule
